// File: rtl/star_scan_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// star_scan_sequencer_pkg
//   Shared constants for the star scan sequencer slice: image geometry,
//   dark-pixel threshold, bus widths, FSM state encoding and the raster
//   cell-index helper used for the claimed-pixel mask.
// ---------------------------------------------------------------------------
package star_scan_sequencer_pkg;

  // Image geometry and pixel classification
  localparam int IMG_WIDTH     = 6;
  localparam int IMG_HEIGHT    = 6;
  localparam int PIX_THRESHOLD = 0;

  // Bus widths
  localparam int ADDR_W = 6;   // image RAM address
  localparam int PIX_W  = 3;   // image RAM data
  localparam int CNT_W  = 4;   // star counter, saturates at all-ones

  // FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_LAUNCH  = 3'd3;
  localparam logic [2:0] ST_MEASURE = 3'd4;
  localparam logic [2:0] ST_MARK    = 3'd5;
  localparam logic [2:0] ST_ADVANCE = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  // Row-major cell index of (x, y) in an image w columns wide
  function automatic int cellIndex(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/address_translator.sv
// ---------------------------------------------------------------------------
// address_translator
//   Combinational (x, y) -> linear image RAM address, addr = y*WIDTH + x.
//
//   Ports
//     x     in   XSZ      column
//     y     in   YSZ      row
//     addr  out  ADDR_W   linear address
// ---------------------------------------------------------------------------
module address_translator
  import star_scan_sequencer_pkg::*;
#(
  parameter int XSZ   = 3,
  parameter int YSZ   = 3,
  parameter int WIDTH = IMG_WIDTH
) (
  input  logic [XSZ-1:0]    x,
  input  logic [YSZ-1:0]    y,
  output logic [ADDR_W-1:0] addr
);

  always_comb begin
    addr = ADDR_W'(int'(y) * WIDTH + int'(x));
  end

endmodule

// File: rtl/star_scan_sequencer.sv
// ---------------------------------------------------------------------------
// star_scan_sequencer
//   Raster-scans an image held in an external RAM. Every bright pixel that is
//   not already covered by a previously measured star seeds the external
//   top/bottom measurement engine; the returned bounding rectangle is then
//   claimed cell by cell so the same star is never launched twice.
//
//   Ports
//     clk          in   1        rising-edge clock
//     reset        in   1        asynchronous, active-high reset
//     scan_go      in   1        pulse: start a full-frame scan (IDLE/DONE only)
//     pix_addr     out  6        image RAM read address, y*WIDTH+x
//     pix_val      in   3        image RAM data, one cycle after pix_addr
//     meas_start   out  1        pulse launching the measurement engine
//     meas_x/y     out  XSZ/YSZ  seed coordinate, held through the measurement
//     meas_done    in   1        engine completion (only honoured in MEASURE)
//     meas_top     in   YSZ      engine top row
//     meas_bottom  in   YSZ      engine bottom row
//     meas_right   in   XSZ      engine right-edge column
//     star_valid   out  1        pulse: star_* hold a fresh result
//     star_top     out  YSZ      latched top row
//     star_bottom  out  YSZ      latched bottom row
//     star_mid     out  XSZ      latched horizontal midpoint
//     star_count   out  4        stars found this scan, saturating
//     busy         out  1        scan in progress (not IDLE, not DONE)
//     scan_done    out  1        scan finished (DONE)
// ---------------------------------------------------------------------------
module star_scan_sequencer
  import star_scan_sequencer_pkg::*;
#(
  parameter int XSZ       = 3,
  parameter int YSZ       = 3,
  parameter int WIDTH     = IMG_WIDTH,
  parameter int HEIGHT    = IMG_HEIGHT,
  parameter int THRESHOLD = PIX_THRESHOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_go,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [PIX_W-1:0]  pix_val,
  output logic              meas_start,
  output logic [XSZ-1:0]    meas_x,
  output logic [YSZ-1:0]    meas_y,
  input  logic              meas_done,
  input  logic [YSZ-1:0]    meas_top,
  input  logic [YSZ-1:0]    meas_bottom,
  input  logic [XSZ-1:0]    meas_right,
  output logic              star_valid,
  output logic [YSZ-1:0]    star_top,
  output logic [YSZ-1:0]    star_bottom,
  output logic [XSZ-1:0]    star_mid,
  output logic [CNT_W-1:0]  star_count,
  output logic              busy,
  output logic              scan_done
);

  localparam int               CELLS    = WIDTH * HEIGHT;
  localparam logic [XSZ-1:0]   X_LAST   = XSZ'(WIDTH - 1);
  localparam logic [YSZ-1:0]   Y_LAST   = YSZ'(HEIGHT - 1);
  localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESHOLD);

  logic [2:0]        state;
  logic [XSZ-1:0]    x;
  logic [YSZ-1:0]    y;
  logic [CELLS-1:0]  claimed;

  // Rectangle walker used while claiming a measured star
  logic [XSZ-1:0]    markX;
  logic [YSZ-1:0]    markY;
  logic [XSZ-1:0]    markXHi;
  logic [YSZ-1:0]    markYHi;
  logic [ADDR_W-1:0] markIdx;

  // Engine results clamped into a legal, non-empty rectangle
  logic [XSZ-1:0]    rightClamped;
  logic [YSZ-1:0]    topClamped;
  logic [YSZ-1:0]    bottomClamped;

  // One extra bit so the seed+right sum cannot wrap before halving
  logic [XSZ:0]      midSum;
  logic              brightFree;

  address_translator #(
    .XSZ   (XSZ),
    .YSZ   (YSZ),
    .WIDTH (WIDTH)
  ) u_addr (
    .x    (x),
    .y    (y),
    .addr (pix_addr)
  );

  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign scan_done  = (state == ST_DONE);
  assign meas_start = (state == ST_LAUNCH);

  assign midSum     = {1'b0, meas_x} + {1'b0, meas_right};
  assign markIdx    = ADDR_W'(cellIndex(int'(markX), int'(markY), WIDTH));
  assign brightFree = (pix_val > THRESH_V) && !claimed[pix_addr];

  // NOTE: every variable gets a value on every path through always_comb;
  // the defaults-then-override shape is what keeps latches out.
  always_comb begin
    rightClamped = meas_right;
    if (meas_right < meas_x) rightClamped = meas_x;
    if (rightClamped > X_LAST) rightClamped = X_LAST;

    topClamped = meas_top;
    if (meas_top > Y_LAST) topClamped = Y_LAST;

    bottomClamped = meas_bottom;
    if (meas_bottom < topClamped) bottomClamped = topClamped;
    if (bottomClamped > Y_LAST) bottomClamped = Y_LAST;
  end

  // NOTE: sequential state is updated with <= only, so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      meas_x      <= '0;
      meas_y      <= '0;
      star_valid  <= 1'b0;
      star_top    <= '0;
      star_bottom <= '0;
      star_mid    <= '0;
      star_count  <= '0;
      markX       <= '0;
      markY       <= '0;
      markXHi     <= '0;
      markYHi     <= '0;
      // NOTE: the claimed mask is a flop vector, not a RAM, so it takes the
      // async reset like any other state; it is also wiped on every scan_go.
      claimed     <= '0;
    end else begin
      star_valid <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (scan_go) begin
            x          <= '0;
            y          <= '0;
            star_count <= '0;
            claimed    <= '0;
            state      <= ST_ISSUE;
          end
        end

        // Address is already on pix_addr; the RAM answers next cycle
        ST_ISSUE: state <= ST_CHECK;

        ST_CHECK: begin
          if (brightFree) begin
            meas_x <= x;
            meas_y <= y;
            state  <= ST_LAUNCH;
          end else begin
            state  <= ST_ADVANCE;
          end
        end

        ST_LAUNCH: state <= ST_MEASURE;

        ST_MEASURE: begin
          if (meas_done) begin
            star_top    <= meas_top;
            star_bottom <= meas_bottom;
            star_mid    <= midSum[XSZ:1];
            star_valid  <= 1'b1;
            if (star_count != '1) star_count <= star_count + 1'b1;
            markX       <= meas_x;
            markY       <= topClamped;
            markXHi     <= rightClamped;
            markYHi     <= bottomClamped;
            state       <= ST_MARK;
          end
        end

        // Row-major walk of the clamped rectangle, one cell per cycle
        ST_MARK: begin
          claimed[markIdx] <= 1'b1;
          if (markX == markXHi) begin
            if (markY == markYHi) begin
              state <= ST_ADVANCE;
            end else begin
              markX <= meas_x;
              markY <= markY + 1'b1;
            end
          end else begin
            markX <= markX + 1'b1;
          end
        end

        ST_ADVANCE: begin
          if (x == X_LAST) begin
            if (y == Y_LAST) begin
              state <= ST_DONE;
            end else begin
              x     <= '0;
              y     <= y + 1'b1;
              state <= ST_ISSUE;
            end
          end else begin
            x     <= x + 1'b1;
            state <= ST_ISSUE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_star_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_star_scan_sequencer
//   Self-checking bench for star_scan_sequencer. A scan-level model walks the
//   image in raster order and predicts the launches, star results and the
//   number of busy cycles; one compare process checks every meas_start and
//   star_valid against it. Directed scans also carry literal expectations.
// ---------------------------------------------------------------------------
module tb_star_scan_sequencer;

  localparam int W   = 6;
  localparam int H   = 6;
  localparam int THR = 0;

  typedef struct {
    int x;
    int y;
    int top;
    int bot;
    int mid;
    int cnt;
  } star_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_go;
  logic [5:0] pix_addr;
  logic [2:0] pix_val = '0;
  logic       meas_start;
  logic [2:0] meas_x;
  logic [2:0] meas_y;
  logic       meas_done;
  logic [2:0] meas_top;
  logic [2:0] meas_bottom;
  logic [2:0] meas_right;
  logic       star_valid;
  logic [2:0] star_top;
  logic [2:0] star_bottom;
  logic [2:0] star_mid;
  logic [3:0] star_count;
  logic       busy;
  logic       scan_done;

  star_scan_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .scan_go     (scan_go),
    .pix_addr    (pix_addr),
    .pix_val     (pix_val),
    .meas_start  (meas_start),
    .meas_x      (meas_x),
    .meas_y      (meas_y),
    .meas_done   (meas_done),
    .meas_top    (meas_top),
    .meas_bottom (meas_bottom),
    .meas_right  (meas_right),
    .star_valid  (star_valid),
    .star_top    (star_top),
    .star_bottom (star_bottom),
    .star_mid    (star_mid),
    .star_count  (star_count),
    .busy        (busy),
    .scan_done   (scan_done)
  );

  always #5 clk = ~clk;

  // Image and engine configuration, written by the main sequence
  logic [2:0] img [W*H];
  int respTop   [4];
  int respBot   [4];
  int respRight [4];
  int measDelay = 1;
  int pokeReq   = 0;

  // Model output
  star_t launchQ[$];
  star_t starQ[$];
  int    expBusy;
  int    expCount;

  // Observation counters (compare process only)
  int busyCycles    = 0;
  int starValidSeen = 0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Synchronous image RAM, one cycle read latency
  always @(posedge clk) begin
    pix_val <= (int'(pix_addr) < W*H) ? img[pix_addr] : 3'd0;
  end

  // Measurement engine: answers measDelay cycles after meas_start with the
  // next canned response; pokeReq injects a stray meas_done.
  initial begin : engine
    int engCnt;
    int engIdx;
    int pokeSeen;
    engCnt      = 0;
    engIdx      = 0;
    pokeSeen    = 0;
    meas_done   = 1'b0;
    meas_top    = '0;
    meas_bottom = '0;
    meas_right  = '0;
    forever begin
      @(negedge clk);
      meas_done = 1'b0;
      if (pokeReq != pokeSeen) begin
        pokeSeen    = pokeReq;
        meas_done   = 1'b1;
        meas_top    = 3'd3;
        meas_bottom = 3'd4;
        meas_right  = 3'd5;
      end
      if (!busy) begin
        engCnt = 0;
        engIdx = 0;
      end else if (engCnt > 0) begin
        engCnt--;
        if (engCnt == 0) begin
          meas_done   = 1'b1;
          meas_top    = 3'(respTop[engIdx]);
          meas_bottom = 3'(respBot[engIdx]);
          meas_right  = 3'(respRight[engIdx]);
          engIdx++;
        end
      end else if (meas_start) begin
        engCnt = measDelay;
      end
    end
  end

  // Compare process
  star_t cmpE;
  always @(negedge clk) begin
    check("start_valid_excl", int'(meas_start & star_valid), 0);
    if (busy) busyCycles++;
    if (meas_start) begin
      if (launchQ.size() == 0) begin
        check("unexpected_launch", 1, 0);
      end else begin
        cmpE = launchQ.pop_front();
        check("launch_x", int'(meas_x), cmpE.x);
        check("launch_y", int'(meas_y), cmpE.y);
      end
    end
    if (star_valid) begin
      starValidSeen++;
      if (starQ.size() == 0) begin
        check("unexpected_star", 1, 0);
      end else begin
        cmpE = starQ.pop_front();
        check("star_top", int'(star_top), cmpE.top);
        check("star_bottom", int'(star_bottom), cmpE.bot);
        check("star_mid", int'(star_mid), cmpE.mid);
        check("star_count", int'(star_count), cmpE.cnt);
      end
    end
  end

  // Scan-level model: raster walk with a claimed map and clamped rectangles
  task automatic buildModel();
    bit cl [W*H];
    int k;
    int xr, yt, yb, cells;
    star_t e;
    launchQ.delete();
    starQ.delete();
    foreach (cl[i]) cl[i] = 1'b0;
    k       = 0;
    expBusy = 0;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        expBusy += 3;
        if (int'(img[yy*W+xx]) > THR && !cl[yy*W+xx]) begin
          e.x   = xx;
          e.y   = yy;
          e.top = respTop[k];
          e.bot = respBot[k];
          e.mid = ((xx + respRight[k]) / 2) % 8;
          e.cnt = (k + 1 > 15) ? 15 : k + 1;
          launchQ.push_back(e);
          starQ.push_back(e);
          xr = (respRight[k] < xx) ? xx : respRight[k];
          if (xr > W-1) xr = W-1;
          yt = (respTop[k] > H-1) ? H-1 : respTop[k];
          yb = (respBot[k] < yt) ? yt : respBot[k];
          if (yb > H-1) yb = H-1;
          cells = 0;
          for (int ry = yt; ry <= yb; ry++)
            for (int rx = xx; rx <= xr; rx++) begin
              cl[ry*W+rx] = 1'b1;
              cells++;
            end
          expBusy += 1 + measDelay + cells;
          k++;
        end
      end
    end
    expCount = (k > 15) ? 15 : k;
  endtask

  task automatic clearImg();
    foreach (img[i]) img[i] = 3'd0;
  endtask

  task automatic setPix(input int px, input int py, input int v);
    img[py*W+px] = 3'(v);
  endtask

  task automatic setResp(input int k, input int t, input int b, input int r);
    respTop[k]   = t;
    respBot[k]   = b;
    respRight[k] = r;
  endtask

  task automatic runScan(input string tag, input int delay, input int glitch,
                         input int litBusy, input int litCount);
    int b0;
    int holdCount;
    measDelay = delay;
    buildModel();
    b0 = busyCycles;
    @(negedge clk) scan_go = 1'b1;
    @(negedge clk) scan_go = 1'b0;
    check({tag, "_first_addr"}, int'(pix_addr), 0);
    check({tag, "_busy_start"}, int'(busy), 1);
    if (glitch != 0) begin
      for (int i = 0; i < 400 && !meas_start; i++) @(negedge clk);
      check({tag, "_glitch_launch_seen"}, int'(meas_start), 1);
      @(negedge clk) scan_go = 1'b1;
      @(negedge clk) scan_go = 1'b0;
    end
    for (int i = 0; i < 2000 && !scan_done; i++) @(negedge clk);
    check({tag, "_scan_done"}, int'(scan_done), 1);
    check({tag, "_busy_cycles_model"}, busyCycles - b0, expBusy);
    check({tag, "_busy_cycles"}, busyCycles - b0, litBusy);
    check({tag, "_count_model"}, int'(star_count), expCount);
    check({tag, "_count"}, int'(star_count), litCount);
    check({tag, "_launches_left"}, launchQ.size(), 0);
    check({tag, "_stars_left"}, starQ.size(), 0);
    holdCount = int'(star_count);
    repeat (3) @(negedge clk);
    check({tag, "_hold_done"}, int'(scan_done), 1);
    check({tag, "_hold_count"}, int'(star_count), holdCount);
  endtask

  initial begin : main
    int sv0;
    reset   = 1'b1;
    scan_go = 1'b0;
    clearImg();
    for (int k = 0; k < 4; k++) setResp(k, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(scan_done), 0);
    check("rst_addr", int'(pix_addr), 0);
    check("rst_count", int'(star_count), 0);
    check("rst_valid", int'(star_valid), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // All-dark frame: 36 ISSUE/CHECK/ADVANCE triples, no launch
    runScan("dark", 1, 0, 108, 0);

    // 2x3 block at x=2..3, y=1..3: single launch at (2,1), mid 2
    clearImg();
    for (int yy = 1; yy <= 3; yy++)
      for (int xx = 2; xx <= 3; xx++) setPix(xx, yy, 5);
    setResp(0, 1, 3, 3);
    runScan("block", 2, 0, 117, 1);
    check("block_mid", int'(star_mid), 2);
    check("block_top", int'(star_top), 1);
    check("block_bottom", int'(star_bottom), 3);
    // Restart from DONE: the claimed mask must be wiped
    runScan("block_again", 2, 0, 117, 1);

    // Stars at (0,0) and (5,5); second response overshoots the edges
    clearImg();
    setPix(0, 0, 7);
    setPix(5, 5, 1);
    setResp(0, 0, 0, 0);
    setResp(1, 5, 7, 7);
    runScan("two", 1, 0, 114, 2);
    check("two_mid", int'(star_mid), 6);
    check("two_bottom", int'(star_bottom), 7);

    // right=1 for seed x=3 clamps to a single column
    clearImg();
    setPix(3, 2, 2);
    setPix(3, 3, 2);
    setPix(2, 3, 2);
    setResp(0, 2, 3, 1);
    setResp(1, 3, 3, 2);
    runScan("clamp", 2, 0, 117, 2);
    check("clamp_mid", int'(star_mid), 2);

    // Reset three cycles into MEASURE aborts without a star
    clearImg();
    for (int yy = 1; yy <= 3; yy++)
      for (int xx = 2; xx <= 3; xx++) setPix(xx, yy, 5);
    setResp(0, 1, 3, 3);
    measDelay = 20;
    buildModel();
    sv0 = starValidSeen;
    @(negedge clk) scan_go = 1'b1;
    @(negedge clk) scan_go = 1'b0;
    for (int i = 0; i < 400 && !meas_start; i++) @(negedge clk);
    check("abort_launch_seen", int'(meas_start), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(scan_done), 0);
    check("abort_addr", int'(pix_addr), 0);
    check("abort_meas_x", int'(meas_x), 0);
    check("abort_meas_y", int'(meas_y), 0);
    check("abort_star_top", int'(star_top), 0);
    check("abort_star_bottom", int'(star_bottom), 0);
    check("abort_star_mid", int'(star_mid), 0);
    check("abort_count", int'(star_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort_no_valid", starValidSeen - sv0, 0);

    // Stray meas_done in IDLE is ignored
    pokeReq++;
    repeat (3) @(negedge clk);
    check("poke_no_valid", starValidSeen - sv0, 0);
    check("poke_busy", int'(busy), 0);
    check("poke_done", int'(scan_done), 0);
    check("poke_top", int'(star_top), 0);
    check("poke_count", int'(star_count), 0);

    // Fresh scan from (0,0) with a scan_go pulse during MEASURE
    runScan("rescan", 2, 1, 117, 1);
    check("rescan_mid", int'(star_mid), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
